// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port program/data memory between the instruction-fetch
// port and the load/store data port. One transaction is in flight at a time.
// The fixed-latency read response is steered back to the port that issued it.
// Data accesses win contention, but after MAX_DATA_STREAK back-to-back data
// grants with a fetch waiting, the fetch is let through so it keeps moving.

module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // instruction-fetch port
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,

    // load/store data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    // memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy
);

    localparam int BE_W     = DATA_W / 8;
    localparam int LAT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0]    LAT_ONE    = LAT_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t                state_reg,   state_next;
    owner_t                owner_reg,   owner_next;
    logic                  store_reg,   store_next;
    logic [LAT_W-1:0]      lat_cnt_reg, lat_cnt_next;
    logic [STREAK_W-1:0]   streak_reg,  streak_next;

    logic                  arb_open;
    logic                  pick_data;
    logic                  pick_fetch;
    logic                  resp_fire;

    // Grants and responses are suppressed while reset is asserted so that the
    // outputs are quiet during reset even though reset is synchronous.
    assign arb_open  = rst_n && (state_reg == ST_IDLE);
    assign resp_fire = rst_n && (state_reg == ST_WAIT) && (lat_cnt_reg == LAT_ONE);

    // Combinational arbitration: data first unless the fetch streak guard trips.
    always_comb begin
        pick_data  = 1'b0;
        pick_fetch = 1'b0;
        if (arb_open) begin
            if (d_req && !(if_req && (streak_reg == STREAK_MAX))) begin
                pick_data = 1'b1;
            end else if (if_req) begin
                pick_fetch = 1'b1;
            end
        end
    end

    // Next-state logic: transaction tracking, latency countdown and streak count.
    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        store_next   = store_reg;
        lat_cnt_next = lat_cnt_reg;
        streak_next  = streak_reg;

        case (state_reg)
            ST_IDLE: begin
                if (pick_data) begin
                    state_next   = ST_WAIT;
                    owner_next   = OWN_DATA;
                    store_next   = d_we;
                    lat_cnt_next = LAT_INIT;
                    // Only a waiting fetch makes a data grant count toward the streak.
                    if (!if_req) begin
                        streak_next = '0;
                    end else if (streak_reg != STREAK_MAX) begin
                        streak_next = streak_reg + STREAK_ONE;
                    end
                end else if (pick_fetch) begin
                    state_next   = ST_WAIT;
                    owner_next   = OWN_FETCH;
                    store_next   = 1'b0;
                    lat_cnt_next = LAT_INIT;
                    streak_next  = '0;
                end
            end

            ST_WAIT: begin
                lat_cnt_next = lat_cnt_reg - LAT_ONE;
                // The response cycle also closes the transaction; a zero count
                // cannot occur here but is treated the same way for safety.
                if (lat_cnt_reg <= LAT_ONE) begin
                    state_next   = ST_IDLE;
                    lat_cnt_next = '0;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                lat_cnt_next = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= OWN_FETCH;
            store_reg   <= 1'b0;
            lat_cnt_reg <= '0;
            streak_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            store_reg   <= store_next;
            lat_cnt_reg <= lat_cnt_next;
            streak_reg  <= streak_next;
        end
    end

    // Request side: grants and the memory strobe, driven from the winner only.
    always_comb begin
        if_gnt    = pick_fetch;
        d_gnt     = pick_data;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;

        if (pick_data) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (pick_fetch) begin
            mem_req   = 1'b1;
            mem_addr  = if_addr;
            mem_be    = {BE_W{1'b1}};
        end
    end

    // Response side: route the single rvalid pulse and its data to the owner.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;

        if (resp_fire) begin
            if (owner_reg == OWN_FETCH) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                // Stores get a bare acknowledge with zero data.
                d_rdata  = store_reg ? '0 : mem_rdata;
            end
        end
    end

    assign busy = rst_n && (state_reg == ST_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Two instances share one clock/reset:
// dut_a with MEM_LATENCY=1 carries most scenarios, dut_b with MEM_LATENCY=3
// covers the longer response delay. Each has a small behavioural memory.

module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- dut_a (MEM_LATENCY=1, MAX_DATA_STREAK=4) ----------------
    logic        if_req_a, if_gnt_a, if_rvalid_a;
    logic [31:0] if_addr_a, if_rdata_a;
    logic        d_req_a, d_we_a, d_gnt_a, d_rvalid_a;
    logic [31:0] d_addr_a, d_wdata_a, d_rdata_a;
    logic [3:0]  d_be_a;
    logic        mem_req_a, mem_we_a, busy_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [3:0]  mem_be_a;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_DATA_STREAK(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
        .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
        .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .d_be(d_be_a), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_be(mem_be_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a)
    );

    // ---------------- dut_b (MEM_LATENCY=3, MAX_DATA_STREAK=4) ----------------
    logic        if_req_b, if_gnt_b, if_rvalid_b;
    logic [31:0] if_addr_b, if_rdata_b;
    logic        d_req_b, d_we_b, d_gnt_b, d_rvalid_b;
    logic [31:0] d_addr_b, d_wdata_b, d_rdata_b;
    logic [3:0]  d_be_b;
    logic        mem_req_b, mem_we_b, busy_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [3:0]  mem_be_b;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_DATA_STREAK(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_be(d_be_b), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_be(mem_be_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b)
    );

    // ---------------- behavioural memories ----------------
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] rd_a;
    logic [31:0] rd_b [0:2];

    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = rd_b[2];

    // Memory A: preloaded during reset, byte-enabled writes, 1-cycle read.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_a[8'h04] <= 32'h0010_0093;
            mem_a[8'h05] <= 32'h1111_1111;
            mem_a[8'h08] <= 32'hFFFF_0000;
            mem_a[8'h80] <= 32'hDDDD_0000;
            rd_a         <= 32'h0;
        end else begin
            if (mem_req_a && mem_we_a) begin
                for (int k = 0; k < 4; k++) begin
                    if (mem_be_a[k]) mem_a[mem_addr_a[9:2]][k*8 +: 8] <= mem_wdata_a[k*8 +: 8];
                end
            end
            rd_a <= (mem_req_a && !mem_we_a) ? mem_a[mem_addr_a[9:2]] : 32'h0;
        end
    end

    // Memory B: read-only contents, 3-cycle read pipeline.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_b[8'h10] <= 32'hCAFE_F00D;
            mem_b[8'h11] <= 32'h1234_5678;
            rd_b[0] <= 32'h0;
            rd_b[1] <= 32'h0;
            rd_b[2] <= 32'h0;
        end else begin
            rd_b[0] <= (mem_req_b && !mem_we_b) ? mem_b[mem_addr_b[9:2]] : 32'h0;
            rd_b[1] <= rd_b[0];
            rd_b[2] <= rd_b[1];
        end
    end

    // ---------------- checking ----------------
    int assert_cnt = 0;
    int fail_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One arbitration round on dut_a: grant cycle then response cycle.
    // exp_data=1 means the data port must win; exp_rd is the owner's rdata.
    task automatic do_grant(input string tag, input logic exp_data, input logic [31:0] exp_rd);
        next_cycle();
        #2;
        check_eq({tag, "_gnt"}, {30'd0, if_gnt_a, d_gnt_a}, exp_data ? 32'd1 : 32'd2);
        $display("txn %s: if_gnt=%0b d_gnt=%0b addr=0x%08h", tag, if_gnt_a, d_gnt_a, mem_addr_a);
        next_cycle();
        #2;
        check_eq({tag, "_rvalid"}, {30'd0, if_rvalid_a, d_rvalid_a}, exp_data ? 32'd1 : 32'd2);
        check_eq({tag, "_rdata"}, exp_data ? d_rdata_a : if_rdata_a, exp_rd);
        check_eq({tag, "_other_rdata"}, exp_data ? if_rdata_a : d_rdata_a, 32'h0);
    endtask

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    bit contention_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        if_req_a = 1'b1; if_addr_a = 32'h0; d_req_a = 1'b1; d_we_a = 1'b0;
        d_addr_a = 32'h0; d_wdata_a = 32'h0; d_be_a = 4'h0;
        if_req_b = 1'b0; if_addr_b = 32'h0; d_req_b = 1'b0; d_we_b = 1'b0;
        d_addr_b = 32'h0; d_wdata_b = 32'h0; d_be_b = 4'h0;

        // ---- reset: requests pending but everything quiet ----
        repeat (2) next_cycle();
        #2;
        check_eq("rst_if_gnt", {31'd0, if_gnt_a}, 32'd0);
        check_eq("rst_d_gnt", {31'd0, d_gnt_a}, 32'd0);
        check_eq("rst_mem_req", {31'd0, mem_req_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_mem_addr", mem_addr_a, 32'd0);

        next_cycle();
        rst_n = 1'b1; if_req_a = 1'b0; d_req_a = 1'b0;
        #2;
        check_eq("rel_mem_req", {31'd0, mem_req_a}, 32'd0);
        check_eq("rel_rvalid", {30'd0, if_rvalid_a, d_rvalid_a}, 32'd0);
        check_eq("rel_busy", {31'd0, busy_a}, 32'd0);

        // ---- fetch only ----
        next_cycle();
        if_req_a = 1'b1; if_addr_a = 32'h10;
        #2;
        $display("txn fetch0: if_gnt=%0b addr=0x%08h", if_gnt_a, mem_addr_a);
        check_eq("f0_if_gnt", {31'd0, if_gnt_a}, 32'd1);
        check_eq("f0_d_gnt", {31'd0, d_gnt_a}, 32'd0);
        check_eq("f0_mem_req", {31'd0, mem_req_a}, 32'd1);
        check_eq("f0_mem_addr", mem_addr_a, 32'h10);
        check_eq("f0_mem_we", {31'd0, mem_we_a}, 32'd0);
        check_eq("f0_mem_be", {28'd0, mem_be_a}, 32'hF);

        next_cycle();
        if_addr_a = 32'h14;
        #2;
        check_eq("f0_if_rvalid", {31'd0, if_rvalid_a}, 32'd1);
        check_eq("f0_if_rdata", if_rdata_a, 32'h0010_0093);
        check_eq("f0_resp_no_gnt", {31'd0, if_gnt_a}, 32'd0);
        check_eq("f0_busy", {31'd0, busy_a}, 32'd1);
        check_eq("f0_d_side", {d_rvalid_a, d_rdata_a[30:0]}, 32'd0);

        next_cycle();
        #2;
        $display("txn fetch1: if_gnt=%0b addr=0x%08h", if_gnt_a, mem_addr_a);
        check_eq("f1_if_gnt", {31'd0, if_gnt_a}, 32'd1);
        check_eq("f1_mem_addr", mem_addr_a, 32'h14);

        next_cycle();
        if_req_a = 1'b0;
        #2;
        check_eq("f1_if_rvalid", {31'd0, if_rvalid_a}, 32'd1);
        check_eq("f1_if_rdata", if_rdata_a, 32'h1111_1111);

        // ---- store then load ----
        next_cycle();
        d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 32'h100; d_wdata_a = 32'h37; d_be_a = 4'hF;
        #2;
        $display("txn store0: d_gnt=%0b addr=0x%08h wdata=0x%08h", d_gnt_a, mem_addr_a, mem_wdata_a);
        check_eq("st_d_gnt", {31'd0, d_gnt_a}, 32'd1);
        check_eq("st_mem_we", {31'd0, mem_we_a}, 32'd1);
        check_eq("st_mem_be", {28'd0, mem_be_a}, 32'hF);
        check_eq("st_mem_wdata", mem_wdata_a, 32'h37);

        next_cycle();
        d_req_a = 1'b0;
        #2;
        check_eq("st_d_rvalid", {31'd0, d_rvalid_a}, 32'd1);
        check_eq("st_d_rdata", d_rdata_a, 32'h0);

        next_cycle();
        d_req_a = 1'b1; d_we_a = 1'b0; d_be_a = 4'h0;
        #2;
        $display("txn load0: d_gnt=%0b addr=0x%08h", d_gnt_a, mem_addr_a);
        check_eq("ld_d_gnt", {31'd0, d_gnt_a}, 32'd1);
        check_eq("ld_mem_we", {31'd0, mem_we_a}, 32'd0);

        next_cycle();
        d_req_a = 1'b0;
        #2;
        check_eq("ld_d_rvalid", {31'd0, d_rvalid_a}, 32'd1);
        check_eq("ld_d_rdata", d_rdata_a, 32'h37);
        check_eq("ld_if_rvalid", {31'd0, if_rvalid_a}, 32'd0);

        // partial store: byte enables pass through untouched
        next_cycle();
        d_req_a = 1'b1; d_we_a = 1'b1; d_wdata_a = 32'h0000_AB00; d_be_a = 4'h2;
        #2;
        $display("txn store1: d_gnt=%0b be=0x%0h", d_gnt_a, mem_be_a);
        check_eq("st1_mem_be", {28'd0, mem_be_a}, 32'h2);
        check_eq("st1_mem_wdata", mem_wdata_a, 32'h0000_AB00);

        next_cycle();
        #2;
        check_eq("st1_d_rdata", {d_rvalid_a, d_rdata_a[30:0]}, 32'h8000_0000);

        // ---- contention: both held high, streak starts at 0 ----
        if_req_a = 1'b1; if_addr_a = 32'h20;
        d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 32'h200; d_be_a = 4'h0;
        for (int i = 0; i < 10; i++) begin
            do_grant($sformatf("cont%0d", i), contention_seq[i],
                     contention_seq[i] ? 32'hDDDD_0000 : 32'hFFFF_0000);
        end

        // ---- streak reset by a data grant without a waiting fetch ----
        for (int i = 0; i < 3; i++) do_grant($sformatf("sr%0d", i), 1'b1, 32'hDDDD_0000);
        if_req_a = 1'b0;
        do_grant("sr3", 1'b1, 32'hDDDD_0000);
        if_req_a = 1'b1;
        for (int i = 0; i < 4; i++) do_grant($sformatf("sr%0d", i + 4), 1'b1, 32'hDDDD_0000);
        do_grant("sr8", 1'b0, 32'hFFFF_0000);

        // ---- reset mid-WAIT after the fourth data grant (streak saturated) ----
        for (int i = 0; i < 3; i++) do_grant($sformatf("rw%0d", i), 1'b1, 32'hDDDD_0000);
        next_cycle();
        #2;
        check_eq("rw3_d_gnt", {31'd0, d_gnt_a}, 32'd1);
        next_cycle();
        rst_n = 1'b0;
        #2;
        check_eq("rw_no_rvalid", {30'd0, if_rvalid_a, d_rvalid_a}, 32'd0);
        check_eq("rw_d_rdata", d_rdata_a, 32'h0);
        check_eq("rw_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rw_gnts", {29'd0, if_gnt_a, d_gnt_a, mem_req_a}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        #2;
        // streak is back to 0, so data wins even though four data grants preceded
        $display("txn post_rst: if_gnt=%0b d_gnt=%0b", if_gnt_a, d_gnt_a);
        check_eq("rw_post_gnt", {30'd0, if_gnt_a, d_gnt_a}, 32'd1);
        next_cycle();
        d_req_a = 1'b0; if_addr_a = 32'h10;
        #2;
        check_eq("rw_post_rdata", d_rdata_a, 32'hDDDD_0000);

        // ---- reset one cycle after a fetch grant ----
        next_cycle();
        #2;
        check_eq("rf_if_gnt", {31'd0, if_gnt_a}, 32'd1);
        next_cycle();
        rst_n = 1'b0; if_req_a = 1'b0;
        #2;
        check_eq("rf_if_rvalid", {31'd0, if_rvalid_a}, 32'd0);
        check_eq("rf_if_rdata", if_rdata_a, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        #2;
        check_eq("rf_quiet", {28'd0, busy_a, if_rvalid_a, mem_req_a, if_gnt_a}, 32'd0);

        // ---- dut_b: MEM_LATENCY=3 ----
        next_cycle();
        d_req_b = 1'b1; d_we_b = 1'b0; d_addr_b = 32'h40;
        #2;
        $display("txn lat3_load: d_gnt=%0b addr=0x%08h", d_gnt_b, mem_addr_b);
        check_eq("l3_d_gnt", {31'd0, d_gnt_b}, 32'd1);
        next_cycle();
        d_req_b = 1'b0; if_req_b = 1'b1; if_addr_b = 32'h44;
        for (int i = 1; i <= 2; i++) begin
            #2;
            check_eq($sformatf("l3_wait%0d", i), {29'd0, busy_b, if_gnt_b, d_rvalid_b}, 32'h4);
            next_cycle();
        end
        #2;
        check_eq("l3_resp", {29'd0, busy_b, if_gnt_b, d_rvalid_b}, 32'h5);
        check_eq("l3_d_rdata", d_rdata_b, 32'hCAFE_F00D);
        next_cycle();
        #2;
        $display("txn lat3_fetch: if_gnt=%0b addr=0x%08h", if_gnt_b, mem_addr_b);
        check_eq("l3_next_gnt", {30'd0, busy_b, if_gnt_b}, 32'h1);
        next_cycle();
        if_req_b = 1'b0;
        #2;
        check_eq("l3_f_wait1", {31'd0, if_rvalid_b}, 32'd0);
        next_cycle();
        #2;
        check_eq("l3_f_wait2", {31'd0, if_rvalid_b}, 32'd0);
        next_cycle();
        #2;
        check_eq("l3_f_rvalid", {31'd0, if_rvalid_b}, 32'd1);
        check_eq("l3_f_rdata", if_rdata_b, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port program/data memory between the instruction-fetch port and the load/store data port.
- Admits one transaction at a time and steers the fixed-latency read response back to whichever port issued it.
- Gives data accesses priority, with a starvation guard so fetch always makes progress.
- Sits between the cpu core and the memory module.

Parameters:
- ADDR_W, 32, address width of both ports and of the memory port.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_req cycle to valid mem_rdata; legal range 1..7.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while if_req is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; held with stable if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata/d_be until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response (load data or store ack), one-cycle pulse.
- d_rdata  out  DATA_W  load data; 0 for stores.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables; all ones for fetch.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_req.
- busy  out  1  transaction outstanding (state WAIT).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, owner=FETCH, latency counter=0, streak counter=0.
  - All outputs 0 while in reset and in the cycle after release unless a grant occurs.
- FSM states: IDLE, WAIT.
- IDLE, no request:
  - All gnt outputs, mem_req and all mem_* buses are 0.
- IDLE, at least one req high:
  - Arbitration is combinational; the winner's gnt=1 in the same cycle.
  - mem_req=1 and mem_* driven from the winner; fetch drives mem_we=0 and mem_be all ones.
  - Next state WAIT, owner register = winner, latency counter = MEM_LATENCY.
- Arbitration:
  - d_req alone: data wins. if_req alone: fetch wins.
  - Both high: data wins unless streak==MAX_DATA_STREAK, in which case fetch wins.
- Streak counter, updated at grants:
  - Fetch grant: reset to 0.
  - Data grant with if_req=0: reset to 0.
  - Data grant with if_req=1: increment, saturating at MAX_DATA_STREAK.
- WAIT:
  - Latency counter decrements each cycle; no gnt; mem_req=0.
  - In the cycle the counter reaches 1 (i.e. MEM_LATENCY cycles after the grant cycle), pulse the owner's rvalid for exactly one cycle.
  - Owner's rdata: mem_rdata, or 0 for a store. Non-owner rvalid=0 and rdata=0.
  - Next state IDLE.
- Throughput: one transaction per MEM_LATENCY+1 cycles. No grant is issued in the response cycle; the next grant is possible the cycle after.
- Requests arriving during WAIT are held by the requester and evaluated in IDLE.
- busy=1 exactly while state==WAIT.
- rdata outputs are 0 whenever the corresponding rvalid=0.
- Reset mid-WAIT: the outstanding response is dropped (no rvalid); the FSM returns to IDLE; the memory-side write already issued is not undone.
- A requester dropping req before gnt is a protocol violation; the arbiter only evaluates the current cycle's inputs.
- Latency counter width: $clog2(MEM_LATENCY+1). Streak counter width: $clog2(MAX_DATA_STREAK+1).

Test Plan:
- Fetch only, MEM_LATENCY=1: if_req=1, if_addr=0x10, memory returns 0x00100093 → if_gnt cycle N, if_rvalid=1 and if_rdata=0x00100093 at cycle N+1, next grant no earlier than N+2, d_* stays 0.
- Store then load: d_req with d_we=1, addr 0x100, wdata 0x37, be 0xF, then a load from 0x100 → mem_we=1 and mem_be=0xF on the store grant, d_rvalid with d_rdata=0 for the store, load returns 0x37.
- Contention, MAX_DATA_STREAK=4: if_req and d_req held high continuously → grant order D,D,D,D,F,D,D,D,D,F; exactly one rvalid per grant, routed to the correct port.
- MEM_LATENCY=3: single data load → d_rvalid exactly 3 cycles after d_gnt; busy high for 3 cycles; no gnt during busy even with if_req=1.
- Reset mid-WAIT: rst_n=0 one cycle after a fetch grant → no if_rvalid; all outputs 0; new request after release is granted normally with streak=0.
- Streak reset: three data grants with if_req=1, one data grant with if_req=0, then both requests for 5 more grants → four consecutive D before the first F.
